sound_frame_sequencer: RTL and testbench
========================================

# sound_frame_sequencer

Central timing controller for the four APU sound channels. It divides the system clock down to the 512 Hz frame rate and steps an 8-phase frame sequencer. It emits single-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) tick strobes, and owns the four channel length counters and the per-channel on/off status. Channel datapaths consume its ticks instead of each running private 33 MHz timeouts.

## Interface
Parameters:
- CLK_DIV, 64453: I_CLK cycles per frame step (33 MHz / 512); legal range ≥ 2
- LEN_MAX_SHORT, 64: length counter reload for channels 0, 1, 3
- LEN_MAX_WAVE, 256: length counter reload for channel 2

Ports:
- I_CLK  in  1  system clock; one clock domain only
- I_RESET_L  in  1  reset, asynchronous, active-low
- I_APU_EN  in  1  NR52 bit 7 master enable, level
- I_TRIG  in  4  per-channel trigger pulse, one cycle (NRx4 bit 7 write)
- I_LEN_LOAD  in  4  per-channel length-load pulse, one cycle (NRx1 write)
- I_LEN_DATA  in  8  length data for I_LEN_LOAD; bits [5:0] used for ch 0/1/3, [7:0] for ch 2
- I_LEN_EN  in  4  per-channel length-enable, level (NRx4 bit 6)
- I_CH_DAC_OFF  in  4  per-channel DAC off, level; forces channel off
- O_LEN_TICK  out  1  length clock strobe
- O_SWEEP_TICK  out  1  sweep clock strobe
- O_ENV_TICK  out  1  envelope clock strobe
- O_STEP  out  3  current sequencer step
- O_CH_ON  out  4  channel active status (NR52 bits 3:0)

## Operation
- Divider: div counts 0..CLK_DIV-1 while I_APU_EN=1. At div==CLK_DIV-1 ("wrap"), div returns to 0, the strobes for the current step fire, and step increments mod 8.
- Strobes at wrap, by step:
  - O_LEN_TICK on steps 0, 2, 4, 6
  - O_SWEEP_TICK on steps 2, 6
  - O_ENV_TICK on step 7
- Length counter per channel, 9 bits: cnt[c].
  - Load pulse: cnt = LEN_MAX − data, using 6 or 8 bits of I_LEN_DATA per channel; the result is never 0.
  - Trigger: if cnt==0, reload to LEN_MAX. O_CH_ON[c] is set unless I_CH_DAC_OFF[c]=1.
  - Length tick with I_LEN_EN[c]=1 and cnt≠0: decrement. On reaching 0, O_CH_ON[c] clears.
- I_CH_DAC_OFF[c]=1: O_CH_ON[c] clears immediately (next edge); the counter is untouched.
- Simultaneous events, same channel same cycle:
  - Load beats tick; no decrement that cycle.
  - Trigger beats tick.
  - Load+trigger: load applied first, then the trigger sees the nonzero value, so there is no reload to max.
- I_APU_EN=0: div, step, all cnt and O_CH_ON are held at 0. Strobes stay 0. Loads and triggers are ignored. On re-enable, counting restarts from div=0, step=0.
- Async reset: identical to the APU-disabled state.

## Timing
- Reset values: all outputs 0, div=0, step=0, cnt=0.
- Strobes are registered, high for exactly one cycle, on the edge where div returns to 0. O_STEP updates on that same edge.
- First O_LEN_TICK occurs CLK_DIV cycles after the first enabled edge.
- Counter decrement and O_CH_ON clear occur on the same edge the strobe rises. A channel-off is visible coincident with the strobe.
- Trigger/load to O_CH_ON / cnt update: 1 cycle.
- No handshake. Inputs are sampled every edge; pulses longer than one cycle act repeatedly.

## Structure
- Shared package sound_pkg holds:
  - CH1..CH4 index constants
  - LEN_MAX_SHORT / LEN_MAX_WAVE defaults
  - the 8-entry step→strobe masks
  - CLK_DIV default
- Sub-module sound_length_counter (9-bit counter, load/trigger/tick/enable, on flag) is instantiated 4 times with its max as a parameter.
- Divider and step FSM live in the top module.

## Test plan
- CLK_DIV=4, I_APU_EN=1 for 64 cycles → O_LEN_TICK 8 pulses, O_SWEEP_TICK 4, O_ENV_TICK 2; O_STEP sequence 0..7 repeats.
- Ch0: load data=0x3E (cnt=2), I_LEN_EN=1, trigger → O_CH_ON[0]=1; clears on the 2nd length tick edge.
- Ch2: load data=0x00 (cnt=256), trigger, I_LEN_EN=0 for 600 ticks → O_CH_ON[2] stays 1 and cnt stays 256.
- Ch1 at cnt=0: trigger coincident with a length tick → cnt=64, O_CH_ON[1]=1, no decrement.
- Mid-run I_APU_EN 1→0→1 → all O_CH_ON=0, O_STEP=0; first strobe CLK_DIV cycles after re-enable.
- Assert I_RESET_L low mid-step asynchronously → all outputs 0 before the next clock edge; I_CH_DAC_OFF[3]=1 on an active ch3 → O_CH_ON[3]=0 after 1 cycle.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants and types for the APU frame sequencer and its channel
// length counters.
package sound_pkg;

    localparam int CH1    = 0;
    localparam int CH2    = 1;
    localparam int CH3    = 2;    // wave channel, 8-bit length
    localparam int CH4    = 3;
    localparam int NUM_CH = 4;

    localparam int DEF_CLK_DIV       = 64453;
    localparam int DEF_LEN_MAX_SHORT = 64;
    localparam int DEF_LEN_MAX_WAVE  = 256;

    typedef enum logic [2:0] {
        STEP_0, STEP_1, STEP_2, STEP_3, STEP_4, STEP_5, STEP_6, STEP_7
    } step_e;

    typedef struct packed {
        logic len;
        logic sweep;
        logic env;
    } strobe_t;

    // Strobes fired when the divider wraps while sitting in the indexed step.
    localparam strobe_t STEP_STROBES [8] = '{
        strobe_t'(3'b100), strobe_t'(3'b000), strobe_t'(3'b110), strobe_t'(3'b000),
        strobe_t'(3'b100), strobe_t'(3'b000), strobe_t'(3'b110), strobe_t'(3'b001)
    };

    function automatic step_e step_next(input step_e s);
        return step_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/sound_length_counter.sv
// One channel's length counter and on/off flag.
// Load and trigger both take priority over a length tick in the same cycle.
module sound_length_counter
    import sound_pkg::*;
#(
    parameter int LEN_MAX = DEF_LEN_MAX_SHORT,
    parameter int DATA_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_apu_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_len_data,
    input  logic              i_trig,
    input  logic              i_tick,
    input  logic              i_len_en,
    input  logic              i_dac_off,
    output logic              o_on
);

    localparam logic [8:0] MAX_VAL = 9'(LEN_MAX);

    logic [8:0] r_cnt;
    logic       r_on;
    logic [8:0] w_load_val;
    logic [8:0] w_cnt_base;
    logic [8:0] w_cnt_nxt;
    logic       w_on_nxt;

    assign w_load_val = MAX_VAL - 9'(i_len_data);

    always_comb begin
        // A trigger sees the freshly loaded value, so load+trigger never reloads max.
        w_cnt_base = i_load ? w_load_val : r_cnt;
        w_cnt_nxt  = w_cnt_base;
        w_on_nxt   = r_on;
        if (i_trig) begin
            if (w_cnt_base == 9'd0) begin
                w_cnt_nxt = MAX_VAL;
            end
            w_on_nxt = 1'b1;
        end else if (!i_load && i_tick && i_len_en && (r_cnt != 9'd0)) begin
            w_cnt_nxt = r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
                w_on_nxt = 1'b0;
            end
        end
        if (i_dac_off) begin
            w_on_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 9'd0;
            r_on  <= 1'b0;
        end else if (!i_apu_en) begin
            r_cnt <= 9'd0;
            r_on  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_on  <= w_on_nxt;
        end
    end

    assign o_on = r_on;

endmodule

// File: rtl/sound_frame_sequencer.sv
// APU frame sequencer: divides I_CLK to the 512 Hz frame rate, steps an
// 8-phase sequencer, issues length/sweep/envelope strobes, owns length counters.
//   step | strobes at wrap
//   0,4  | len          2,6 | len + sweep
//   7    | env          odd | none (except 7)
module sound_frame_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int LEN_MAX_SHORT = DEF_LEN_MAX_SHORT,
    parameter int LEN_MAX_WAVE  = DEF_LEN_MAX_WAVE
) (
    input  logic       I_CLK,
    input  logic       I_RESET_L,
    input  logic       I_APU_EN,
    input  logic [3:0] I_TRIG,
    input  logic [3:0] I_LEN_LOAD,
    input  logic [7:0] I_LEN_DATA,
    input  logic [3:0] I_LEN_EN,
    input  logic [3:0] I_CH_DAC_OFF,
    output logic       O_LEN_TICK,
    output logic       O_SWEEP_TICK,
    output logic       O_ENV_TICK,
    output logic [2:0] O_STEP,
    output logic [3:0] O_CH_ON
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    step_e            r_step;
    step_e            w_step_nxt;
    logic             w_wrap;
    strobe_t          w_strobe;
    logic             r_len_tick;
    logic             r_sweep_tick;
    logic             r_env_tick;
    logic [3:0]       w_ch_on;

    assign w_wrap = I_APU_EN && (r_div == DIV_LAST);

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_div <= '0;
        end else if (!I_APU_EN || w_wrap) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_step <= STEP_0;
        end else begin
            r_step <= w_step_nxt;
        end
    end

    always_comb begin
        w_step_nxt = r_step;
        w_strobe   = '0;
        if (!I_APU_EN) begin
            w_step_nxt = STEP_0;
        end else if (w_wrap) begin
            w_step_nxt = step_next(r_step);
            w_strobe   = STEP_STROBES[r_step];
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
        end else begin
            r_len_tick   <= w_strobe.len;
            r_sweep_tick <= w_strobe.sweep;
            r_env_tick   <= w_strobe.env;
        end
    end

    // Counters use the unregistered strobe so a channel-off lands with O_LEN_TICK.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_len
        localparam bit IS_WAVE = (c == CH3);
        localparam int DW      = IS_WAVE ? 8 : 6;

        sound_length_counter #(
            .LEN_MAX (IS_WAVE ? LEN_MAX_WAVE : LEN_MAX_SHORT),
            .DATA_W  (DW)
        ) u_len (
            .i_clk      (I_CLK),
            .i_rst_n    (I_RESET_L),
            .i_apu_en   (I_APU_EN),
            .i_load     (I_LEN_LOAD[c]),
            .i_len_data (I_LEN_DATA[DW-1:0]),
            .i_trig     (I_TRIG[c]),
            .i_tick     (w_strobe.len),
            .i_len_en   (I_LEN_EN[c]),
            .i_dac_off  (I_CH_DAC_OFF[c]),
            .o_on       (w_ch_on[c])
        );
    end

    assign O_LEN_TICK   = r_len_tick;
    assign O_SWEEP_TICK = r_sweep_tick;
    assign O_ENV_TICK   = r_env_tick;
    assign O_STEP       = r_step;
    assign O_CH_ON      = w_ch_on;

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed scoreboard bench for sound_frame_sequencer with a short frame divider.
module tb_sound_frame_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       apu_en;
    logic [3:0] trig;
    logic [3:0] len_load;
    logic [7:0] len_data;
    logic [3:0] len_en;
    logic [3:0] dac_off;
    logic       len_tick;
    logic       sweep_tick;
    logic       env_tick;
    logic [2:0] step;
    logic [3:0] ch_on;

    sound_frame_sequencer #(
        .CLK_DIV (DIV)
    ) dut (
        .I_CLK        (clk),
        .I_RESET_L    (rst_l),
        .I_APU_EN     (apu_en),
        .I_TRIG       (trig),
        .I_LEN_LOAD   (len_load),
        .I_LEN_DATA   (len_data),
        .I_LEN_EN     (len_en),
        .I_CH_DAC_OFF (dac_off),
        .O_LEN_TICK   (len_tick),
        .O_SWEEP_TICK (sweep_tick),
        .O_ENV_TICK   (env_tick),
        .O_STEP       (step),
        .O_CH_ON      (ch_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_len, n_sweep, n_env;

    task automatic expect_val(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input int obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %0d, nothing queued", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp && tag == e.tag) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d (queued for %s)", tag, obs, e.exp, e.tag);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        n_len   += int'(len_tick);
        n_sweep += int'(sweep_tick);
        n_env   += int'(env_tick);
    endtask

    task automatic clr_counts();
        n_len = 0;
        n_sweep = 0;
        n_env = 0;
    endtask

    // Runs until channel ch drops; ticks = length strobes seen, -1 on timeout.
    task automatic run_until_off(input int ch, input int budget, output int ticks, output int tick_at_off);
        ticks = 0;
        tick_at_off = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (len_tick) ticks++;
            if (!ch_on[ch]) begin
                tick_at_off = int'(len_tick);
                return;
            end
        end
        ticks = -1;
    endtask

    // Cycles from now until the first length strobe; -1 on timeout.
    task automatic edges_to_len_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if (len_tick) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, at_off, first, guard;

        rst_l = 1'b0; apu_en = 1'b0; trig = '0; len_load = '0;
        len_data = '0; len_en = '0; dac_off = '0;
        clr_counts();

        // Reset state
        expect_val("rst_len", 0);
        expect_val("rst_sweep", 0);
        expect_val("rst_env", 0);
        expect_val("rst_step", 0);
        expect_val("rst_chon", 0);
        cyc(); cyc();
        check("rst_len", int'(len_tick));
        check("rst_sweep", int'(sweep_tick));
        check("rst_env", int'(env_tick));
        check("rst_step", int'(step));
        check("rst_chon", int'(ch_on));

        // 64 enabled cycles: 16 wraps on cycles 4,8,..,64
        rst_l = 1'b1; apu_en = 1'b1;
        clr_counts();
        first = 0;
        for (int k = 1; k <= 16; k++) expect_val("step_seq", k % 8);
        expect_val("first_len_edge", DIV);
        expect_val("len_pulses", 8);
        expect_val("sweep_pulses", 4);
        expect_val("env_pulses", 2);
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (first == 0 && len_tick) first = i;
            if (i % DIV == 0) check("step_seq", int'(step));
        end
        check("first_len_edge", first);
        check("len_pulses", n_len);
        check("sweep_pulses", n_sweep);
        check("env_pulses", n_env);

        // Ch0: load 0x3E -> 2, trigger, off on second tick
        len_load = 4'b0001; len_data = 8'h3E; cyc(); len_load = '0;
        len_en[0] = 1'b1; trig = 4'b0001;
        expect_val("ch0_on_trig", 1);
        cyc(); trig = '0;
        check("ch0_on_trig", int'(ch_on[0]));
        expect_val("ch0_ticks_to_off", 2);
        expect_val("ch0_off_with_tick", 1);
        run_until_off(0, 200, nt, at_off);
        check("ch0_ticks_to_off", nt);
        check("ch0_off_with_tick", at_off);

        // Ch0: load 0x3F + trigger together -> count 1, no reload to max
        len_load = 4'b0001; trig = 4'b0001; len_data = 8'h3F;
        expect_val("ch0_ldtrig_on", 1);
        cyc(); len_load = '0; trig = '0;
        check("ch0_ldtrig_on", int'(ch_on[0]));
        expect_val("ch0_ldtrig_ticks", 1);
        run_until_off(0, 200, nt, at_off);
        check("ch0_ldtrig_ticks", nt);

        // Ch2: load 0 -> 256, length disabled for 600 ticks
        len_load = 4'b0100; len_data = 8'h00; cyc(); len_load = '0;
        trig = 4'b0100; cyc(); trig = '0;
        clr_counts();
        guard = 0;
        while (n_len < 600 && guard < 600 * 2 * DIV + 50) begin
            cyc();
            guard++;
        end
        expect_val("ch2_held_ticks", 600);
        expect_val("ch2_on_held", 1);
        check("ch2_held_ticks", n_len);
        check("ch2_on_held", int'(ch_on[2]));
        len_en[2] = 1'b1;
        expect_val("ch2_ticks_to_off", 256);
        run_until_off(2, 256 * 2 * DIV + 100, nt, at_off);
        check("ch2_ticks_to_off", nt);

        // Ch1 at count 0: trigger on the same edge as a length tick
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (!env_tick && guard < 10 * 8 * DIV);
        len_en[1] = 1'b1;
        for (int i = 0; i < DIV - 1; i++) cyc();
        trig = 4'b0010;
        expect_val("ch1_trig_tick", 1);
        expect_val("ch1_on", 1);
        cyc(); trig = '0;
        check("ch1_trig_tick", int'(len_tick));
        check("ch1_on", int'(ch_on[1]));
        expect_val("ch1_ticks_to_off", 64);
        run_until_off(1, 64 * 2 * DIV + 100, nt, at_off);
        check("ch1_ticks_to_off", nt);

        // Ch3 active, then APU disable/enable
        trig = 4'b1000;
        expect_val("ch3_on", 1);
        cyc(); trig = '0;
        check("ch3_on", int'(ch_on[3]));
        apu_en = 1'b0;
        expect_val("dis_chon", 0);
        expect_val("dis_step", 0);
        cyc();
        check("dis_chon", int'(ch_on));
        check("dis_step", int'(step));
        trig = 4'hF; len_load = 4'hF; len_data = 8'h10;
        expect_val("dis_ignore_trig", 0);
        cyc(); trig = '0; len_load = '0;
        check("dis_ignore_trig", int'(ch_on));
        clr_counts();
        expect_val("dis_no_strobes", 0);
        for (int i = 0; i < 3 * DIV; i++) cyc();
        check("dis_no_strobes", n_len + n_sweep + n_env);
        apu_en = 1'b1;
        expect_val("reen_first_len", DIV);
        expect_val("reen_step", 1);
        edges_to_len_tick(4 * DIV, first);
        check("reen_first_len", first);
        check("reen_step", int'(step));

        // DAC off on an active ch3
        trig = 4'b1000; cyc(); trig = '0;
        dac_off[3] = 1'b1;
        expect_val("dac_off_ch3", 0);
        cyc();
        check("dac_off_ch3", int'(ch_on[3]));
        trig = 4'b1000;
        expect_val("dac_off_trig", 0);
        cyc(); trig = '0;
        check("dac_off_trig", int'(ch_on[3]));
        dac_off[3] = 1'b0;
        trig = 4'b1000; cyc(); trig = '0;

        // Async reset between edges
        guard = 0;
        while (step == 3'd0 && guard < 2 * DIV) begin
            cyc();
            guard++;
        end
        expect_val("pre_rst_chon", 8);
        check("pre_rst_chon", int'(ch_on));
        #1 rst_l = 1'b0;
        #2;
        expect_val("async_rst_all", 0);
        check("async_rst_all", int'({len_tick, sweep_tick, env_tick, step, ch_on}));
        cyc();
        rst_l = 1'b1;

        expect_val("sb_leftover", 0);
        check("sb_leftover", sb.size() - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
